pc_select: RTL and testbench

Fetch-side PC resolver and F pipeline register for the Y86-64 pipelined processor. It is the consumer end of the fetch-stage PC prediction path.
- Latches the predicted next PC into F_predPC.
- Chooses the actual fetch PC f_pc: corrects jXX mispredictions from the M stage, and ret targets from the W stage.
- Tracks in-flight ret instructions with a small FSM that raises a fetch stall.
- Optionally keeps redirect statistics.

---
 rtl/pc_select.sv | 105 ++++++++++
 tb/tb_pc_select.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_select.sv
// Fetch-side PC resolver and F pipeline register for the Y86-64 pipeline.
// Optional redirect statistics counters are built when PC_SEL_STATS_EN is defined.
module pc_select #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       predPC,
  input  logic [3:0]        f_icode,
  input  logic              F_stall,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [63:0]       M_valA,
  input  logic [3:0]        W_icode,
  input  logic [63:0]       W_valM,
  output logic [63:0]       f_pc,
  output logic [63:0]       F_predPC,
  output logic              mispredict,
  output logic              ret_redirect,
  output logic              ret_stall,
  output logic [CNT_W-1:0]  mispred_count,
  output logic [CNT_W-1:0]  ret_count
);

  localparam logic [3:0] IJXX = 4'd7;
  localparam logic [3:0] IRET = 4'd9;

  typedef enum logic {RUN, RET_WAIT} state_t;

  state_t      r_state;
  logic [63:0] r_pred_pc;
  logic        w_mispredict;
  logic        w_ret_redirect;

  assign w_mispredict   = (M_icode == IJXX) && !M_Cnd;
  assign w_ret_redirect = (W_icode == IRET);

  assign mispredict   = w_mispredict;
  assign ret_redirect = w_ret_redirect;
  assign F_predPC     = r_pred_pc;

  // M-stage correction squashes a same-cycle ret redirect from W.
  always_comb begin
    if (w_mispredict)
      f_pc = M_valA;
    else if (w_ret_redirect)
      f_pc = W_valM;
    else
      f_pc = r_pred_pc;
  end

  assign ret_stall = (r_state == RET_WAIT) && !w_ret_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_pc <= RESET_PC;
    end else if (!F_stall) begin
      r_pred_pc <= predPC;
    end
  end

  // F_stall only gates the entry condition; it never freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if ((f_icode == IRET) && !F_stall && !w_mispredict)
            r_state <= RET_WAIT;
        end
        RET_WAIT: begin
          if (w_mispredict || w_ret_redirect)
            r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef PC_SEL_STATS_EN
  logic [CNT_W-1:0] r_mispred_cnt;
  logic [CNT_W-1:0] r_ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispred_cnt <= '0;
      r_ret_cnt     <= '0;
    end else begin
      if (w_mispredict && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      if (w_ret_redirect && !w_mispredict && (r_ret_cnt != '1))
        r_ret_cnt <= r_ret_cnt + 1'b1;
    end
  end

  assign mispred_count = r_mispred_cnt;
  assign ret_count     = r_ret_cnt;
`else
  assign mispred_count = '0;
  assign ret_count     = '0;
`endif

endmodule

// File: tb/tb_pc_select.sv
// Randomized scoreboard bench for pc_select; expected responses come from a
// cycle-level model of the fetch PC rules and are checked by a separate monitor.
module tb_pc_select;

  localparam logic [63:0] RESET_PC = 64'h100;
  localparam int          CNT_W    = 8;
  localparam int          N_RAND   = 1500;

  logic              clk;
  logic              rst_n;
  logic [63:0]       predPC;
  logic [3:0]        f_icode;
  logic              F_stall;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [63:0]       M_valA;
  logic [3:0]        W_icode;
  logic [63:0]       W_valM;
  logic [63:0]       f_pc;
  logic [63:0]       F_predPC;
  logic              mispredict;
  logic              ret_redirect;
  logic              ret_stall;
  logic [CNT_W-1:0]  mispred_count;
  logic [CNT_W-1:0]  ret_count;

  pc_select #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .predPC(predPC), .f_icode(f_icode),
    .F_stall(F_stall), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc), .F_predPC(F_predPC),
    .mispredict(mispredict), .ret_redirect(ret_redirect), .ret_stall(ret_stall),
    .mispred_count(mispred_count), .ret_count(ret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      f_pc;
    logic [63:0]      pred;
    logic             mis;
    logic             rr;
    logic             rs;
    logic [CNT_W-1:0] mc;
    logic [CNT_W-1:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Model state: what the F register holds, whether a valid-path ret is outstanding.
  logic [63:0]      m_pred = RESET_PC;
  bit               m_ret_pending = 0;
  logic [CNT_W-1:0] m_mc = '0;
  logic [CNT_W-1:0] m_rc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%h required=%h", nm, txn, act, req);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // One cycle: drive inputs just after the edge, predict outputs, advance model to next edge.
  task automatic cyc(input bit rst, input logic [63:0] ppc, input logic [3:0] fi,
                     input bit fs, input logic [3:0] mi, input bit mc,
                     input logic [63:0] mva, input logic [3:0] wi, input logic [63:0] wvm);
    exp_t e;
    bit   mis, rr;
    @(posedge clk);
    #1;
    rst_n = rst; predPC = ppc; f_icode = fi; F_stall = fs;
    M_icode = mi; M_Cnd = mc; M_valA = mva; W_icode = wi; W_valM = wvm;
    if (!rst) begin
      m_pred = RESET_PC; m_ret_pending = 0; m_mc = '0; m_rc = '0;
    end
    mis = (mi == 4'd7) && !mc;
    rr  = (wi == 4'd9);
    e.mis  = mis;
    e.rr   = rr;
    e.f_pc = mis ? mva : (rr ? wvm : m_pred);
    e.pred = m_pred;
    e.rs   = m_ret_pending && !rr;
    e.mc   = m_mc;
    e.rc   = m_rc;
    exp_q.push_back(e);
    if (rst) begin
      if (!fs) m_pred = ppc;
      if (mis)                m_ret_pending = 0;
      else if (m_ret_pending) m_ret_pending = !rr;
      else                    m_ret_pending = (fi == 4'd9) && !fs;
`ifdef PC_SEL_STATS_EN
      if (mis)        m_mc = sat_inc(m_mc);
      if (rr && !mis) m_rc = sat_inc(m_rc);
`endif
    end
  endtask

  task automatic idle(input logic [63:0] ppc);
    cyc(1, ppc, 4'd0, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
  endtask

  // Monitor: compare at the falling edge whenever a response is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d f_pc=%h F_predPC=%h mis=%b rr=%b rs=%b mc=%0d rc=%0d",
                 txn, f_pc, F_predPC, mispredict, ret_redirect, ret_stall,
                 mispred_count, ret_count);
        chk("f_pc", f_pc, e.f_pc);
        chk("F_predPC", F_predPC, e.pred);
        chk("mispredict", {63'd0, mispredict}, {63'd0, e.mis});
        chk("ret_redirect", {63'd0, ret_redirect}, {63'd0, e.rr});
        chk("ret_stall", {63'd0, ret_stall}, {63'd0, e.rs});
        chk("mispred_count", 64'(mispred_count), 64'(e.mc));
        chk("ret_count", 64'(ret_count), 64'(e.rc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ic_tab [0:4];
    ic_tab[0] = 4'd7; ic_tab[1] = 4'd8; ic_tab[2] = 4'd9; ic_tab[3] = 4'd0; ic_tab[4] = 4'd6;
    rst_n = 0; predPC = '0; f_icode = '0; F_stall = 0; M_icode = '0; M_Cnd = 0;
    M_valA = '0; W_icode = '0; W_valM = '0;

    // Reset, then release.
    cyc(0, 64'h0, 4'd0, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    cyc(0, 64'h0, 4'd0, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    idle(64'h10A);
    // Latch 10A, then stall while a new prediction is offered.
    cyc(1, 64'h333, 4'd0, 1, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    idle(64'h300);
    // jXX not taken vs taken.
    cyc(1, 64'h300, 4'd0, 0, 4'd7, 0, 64'h200, 4'd0, 64'h0);
    cyc(1, 64'h300, 4'd0, 0, 4'd7, 1, 64'h200, 4'd0, 64'h0);
    // ret fetched, three bubbles, ret reaches W.
    idle(64'h300);
    cyc(1, 64'h301, 4'd9, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    idle(64'h301); idle(64'h301); idle(64'h301);
    cyc(1, 64'h301, 4'd0, 0, 4'd0, 0, 64'h0, 4'd9, 64'h4F0);
    idle(64'h4F0);
    // ret on a wrong path is squashed by a mispredict.
    cyc(1, 64'h500, 4'd9, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    idle(64'h500);
    cyc(1, 64'h500, 4'd0, 0, 4'd7, 0, 64'h220, 4'd0, 64'h0);
    idle(64'h220);
    // Simultaneous mispredict and ret in W.
    cyc(1, 64'h600, 4'd0, 0, 4'd7, 0, 64'h220, 4'd9, 64'h4F0);
    idle(64'h600);
`ifdef PC_SEL_STATS_EN
    @(posedge clk); #1;
    force dut.r_ret_cnt = '1;
    force dut.r_mispred_cnt = '1;
    m_rc = '1; m_mc = '1;
    cyc(1, 64'h700, 4'd0, 0, 4'd7, 0, 64'h220, 4'd9, 64'h4F0);
    cyc(1, 64'h700, 4'd0, 0, 4'd0, 0, 64'h0, 4'd9, 64'h4F0);
    release dut.r_ret_cnt;
    release dut.r_mispred_cnt;
    cyc(1, 64'h700, 4'd0, 0, 4'd7, 0, 64'h220, 4'd9, 64'h4F0);
    cyc(1, 64'h700, 4'd0, 0, 4'd0, 0, 64'h0, 4'd9, 64'h4F0);
`endif
    // Reset asserted mid-cycle while a ret is outstanding.
    cyc(1, 64'h800, 4'd9, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    cyc(0, 64'h900, 4'd0, 0, 4'd0, 0, 64'h0, 4'd0, 64'h0);
    idle(64'h910);

    for (int i = 0; i < N_RAND; i++) begin
      bit rst;
      rst = ($urandom_range(0, 199) != 0);
      cyc(rst, {$urandom, $urandom}, ic_tab[$urandom_range(0, 4)],
          ($urandom_range(0, 3) == 0), ic_tab[$urandom_range(0, 4)], 1'($urandom),
          {$urandom, $urandom}, ic_tab[$urandom_range(0, 4)], {$urandom, $urandom});
    end

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
